control_sequencer: RTL



---
 rtl/control_sequencer_pkg.sv | 50 +++++
 rtl/control_sequencer_ring_counter.sv | 45 ++++
 rtl/control_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : control_sequencer_pkg                                  |
// | Description : Opcode, control-bit and timing constants shared by the |
// |               sequencer and the datapath register instances.         |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package control_sequencer_pkg;

    localparam int CTRL_W    = 14;
    localparam int INSTR_LEN = 6;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_JMP = 4'b0101;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int CTRL_PC_INC   = 0;
    localparam int CTRL_PC_OUT   = 1;
    localparam int CTRL_PC_LOAD  = 2;
    localparam int CTRL_MAR_LOAD = 3;
    localparam int CTRL_RAM_OUT  = 4;
    localparam int CTRL_RAM_LOAD = 5;
    localparam int CTRL_IR_LOAD  = 6;
    localparam int CTRL_IR_OUT   = 7;
    localparam int CTRL_A_LOAD   = 8;
    localparam int CTRL_A_OUT    = 9;
    localparam int CTRL_B_LOAD   = 10;
    localparam int CTRL_ALU_OUT  = 11;
    localparam int CTRL_SUB      = 12;
    localparam int CTRL_OUT_LOAD = 13;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_e;

    function automatic logic [CTRL_W-1:0] cbit(input int idx);
        logic [CTRL_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer_ring_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ring_counter                                           |
// | Description : One-hot T1..T6 counter with hold, clear, async reset.  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module ring_counter
    import control_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 advance_i,
    output logic [INSTR_LEN-1:0] t_o
);

    logic [INSTR_LEN-1:0] ring_q;
    logic [INSTR_LEN-1:0] ring_d;

    // Advancing from all-zeros starts a new instruction at T1.
    always_comb begin
        ring_d = ring_q;
        if (clear_i) begin
            ring_d = '0;
        end else if (advance_i) begin
            if (ring_q == '0) begin
                ring_d = INSTR_LEN'(1);
            end else begin
                ring_d = {ring_q[INSTR_LEN-2:0], ring_q[INSTR_LEN-1]};
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_q <= '0;
        end else begin
            ring_q <= ring_d;
        end
    end

    assign t_o = ring_q;

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : control_sequencer                                      |
// | Description : Per-T-state control word generator with IDLE/HALTED.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [3:0]           opcode,
    output logic [CTRL_W-1:0]    ctrl,
    output logic                 halt,
    output logic [INSTR_LEN-1:0] t_state
);

    seq_state_e           state_q;
    seq_state_e           state_d;
    logic                 ring_clear;
    logic                 ring_advance;
    logic [INSTR_LEN-1:0] t_q;

    ring_counter u_ring (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (ring_clear),
        .advance_i (ring_advance),
        .t_o       (t_q)
    );

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ring_clear   = 1'b0;
        ring_advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d      = ST_RUN;
                    ring_advance = 1'b1;
                end
            end
            ST_RUN: begin
                // HLT is taken on the edge ending T3, once the IR holds it.
                if (t_q[2] && (opcode == OP_HLT)) begin
                    state_d    = ST_HALTED;
                    ring_clear = 1'b1;
                end else if (t_q[5]) begin
                    if (run) begin
                        ring_advance = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        ring_clear = 1'b1;
                    end
                end else begin
                    ring_advance = 1'b1;
                end
            end
            ST_HALTED: begin
                ring_clear = 1'b1;
            end
            default: begin
                state_d    = ST_IDLE;
                ring_clear = 1'b1;
            end
        endcase
    end

    always_comb begin
        ctrl = '0;
        if (state_q == ST_RUN) begin
            if (t_q[0]) begin
                ctrl = cbit(CTRL_PC_OUT) | cbit(CTRL_MAR_LOAD);
            end else if (t_q[1]) begin
                ctrl = cbit(CTRL_PC_INC);
            end else if (t_q[2]) begin
                ctrl = cbit(CTRL_RAM_OUT) | cbit(CTRL_IR_LOAD);
            end else if (t_q[3]) begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA:
                        ctrl = cbit(CTRL_IR_OUT) | cbit(CTRL_MAR_LOAD);
                    OP_JMP:  ctrl = cbit(CTRL_IR_OUT) | cbit(CTRL_PC_LOAD);
                    OP_OUT:  ctrl = cbit(CTRL_A_OUT) | cbit(CTRL_OUT_LOAD);
                    default: ctrl = '0;
                endcase
            end else if (t_q[4]) begin
                case (opcode)
                    OP_LDA:         ctrl = cbit(CTRL_RAM_OUT) | cbit(CTRL_A_LOAD);
                    OP_ADD, OP_SUB: ctrl = cbit(CTRL_RAM_OUT) | cbit(CTRL_B_LOAD);
                    OP_STA:         ctrl = cbit(CTRL_A_OUT) | cbit(CTRL_RAM_LOAD);
                    default:        ctrl = '0;
                endcase
            end else if (t_q[5]) begin
                case (opcode)
                    OP_ADD:  ctrl = cbit(CTRL_ALU_OUT) | cbit(CTRL_A_LOAD);
                    OP_SUB:  ctrl = cbit(CTRL_ALU_OUT) | cbit(CTRL_A_LOAD) | cbit(CTRL_SUB);
                    default: ctrl = '0;
                endcase
            end
        end
    end

    assign halt    = (state_q == ST_HALTED);
    assign t_state = t_q;

endmodule
`default_nettype wire
